packet_tx_reader: RTL and testbench
===================================

// Module: packet_tx_reader
// PURPOSE
//   Transmit-side counterpart of the receive packet store. Pops packet lengths from the length FIFO,
//   reads payload bytes from the packet RAM, and drives an 8-bit MII-style TX stream: preamble, SFD,
//   payload, then an enforced inter-packet gap (IFG). Sits between the packet memory and the TX PHY.
// PARAMETERS
//   pDATA_WIDTH         8                       byte width of RAM data and TX data
//   pMAX_PACKET_LENGHT  1536                    largest legal packet length in bytes
//   pDEPTH_RAM          2*pMAX_PACKET_LENGHT    packet RAM depth in bytes (3072)
//   pFIFO_WIDTH         $clog2(pMAX_PACKET_LENGHT)  length FIFO word width (11)
//   pPREAMBLE_LEN       7                       number of 0x55 preamble bytes
//   pIFG                12                      minimum idle cycles between packets
// PORTS
//   iclk           in   1                    clock
//   i_rst_n        in   1                    asynchronous reset, active low
//   i_enable       in   1                    allows a new packet to start; never aborts one in flight
//   i_fifo_empty   in   1                    length FIFO empty
//   i_fifo_len     in   pFIFO_WIDTH          FIFO head word (first-word-fall-through; valid when !i_fifo_empty)
//   o_fifo_rd      out  1                    one-cycle pop strobe
//   o_ram_raddr    out  $clog2(pDEPTH_RAM)   packet RAM read address
//   i_ram_rdata    in   pDATA_WIDTH          RAM data; valid one cycle after o_ram_raddr
//   o_tx_en        out  1                    TX byte valid
//   o_tx_d         out  pDATA_WIDTH          TX byte, registered
//   o_busy         out  1                    high from pop until the end of the IFG
//   o_pkt_done     out  1                    one-cycle pulse on the last payload byte
//   o_len_err      out  1                    one-cycle pulse when a popped length is dropped
// BEHAVIOUR
//   Reset (asynchronous, immediate)
//   - All outputs are 0. o_ram_raddr is 0. The internal read pointer is 0. The FSM is in IDLE.
//   FSM states: IDLE -> LOAD -> PRE -> SFD -> DATA -> IFG -> IDLE. LOAD may instead go to DROP -> IDLE.
//   - IDLE: if i_enable & !i_fifo_empty, pulse o_fifo_rd at cycle P and latch i_fifo_len as LEN.
//   - LOAD (P+1): if LEN==0 or LEN>pMAX_PACKET_LENGHT, go to DROP. Otherwise go to PRE.
//   - DROP: pulse o_len_err for 1 cycle. No o_tx_en. Read pointer becomes (ptr+LEN) mod pDEPTH_RAM,
//     which keeps the pointer aligned with the writer. Then go to IDLE.
//   Output timeline for a good packet (T0 = P+2)
//   - T0..T6: o_tx_en=1, o_tx_d=0x55.
//   - T7: o_tx_d=0xD5.
//   - T8..T8+LEN-1: payload byte k = RAM[(base+k) mod pDEPTH_RAM], in order.
//   - o_pkt_done=1 at T8+LEN-1.
//   - T8+LEN: o_tx_en=0 and o_tx_d=0. o_tx_d is 0 whenever o_tx_en=0.
//   RAM addressing
//   - Address base+k is issued 2 cycles before its byte appears on o_tx_d (1 cycle RAM latency, 1 cycle output register).
//   - The address after pDEPTH_RAM-1 is 0.
//   - After the packet, ptr = (base+LEN) mod pDEPTH_RAM.
//   - Sums are formed one bit wider than the address, then reduced by conditional subtract of pDEPTH_RAM.
//   IFG
//   - o_tx_en stays 0 for at least pIFG cycles after the last payload byte.
//   - The next pop happens no earlier than T8+LEN+pIFG-2, so the next T0 is no earlier than T8+LEN+pIFG.
//   - With a non-empty FIFO and i_enable high, the gap is exactly pIFG cycles.
//   - o_busy falls when the FSM returns to IDLE.
//   Enable and reset in flight
//   - i_enable going low mid-packet has no effect; the packet and its IFG complete.
//   - Reset mid-packet truncates the packet: o_tx_en drops immediately and nothing resumes.
//   - The FIFO is never popped while empty. o_fifo_rd is never asserted outside IDLE.
// TESTING
//   - FIFO holds 64, RAM[0..63]=k -> o_fifo_rd at P; 7x0x55 and 0xD5 from P+2; bytes 0x00..0x3F at
//     P+10..P+73; o_pkt_done at P+73; pointer ends at 64.
//   - Wrap: pointer at 3070, LEN=4 -> addresses 3070,3071,0,1 in order; pointer ends at 2.
//   - Two queued lengths 64,100 with i_enable held high -> exactly 12 idle cycles between the last byte
//     of packet 1 and the preamble of packet 2; 2 pops total.
//   - LEN=0 -> o_len_err pulse, no o_tx_en, pointer unchanged. LEN=1600 at ptr 0 -> o_len_err, no TX,
//     pointer ends at 1600.
//   - i_enable low with the FIFO non-empty -> no pop. Drop i_enable mid-payload -> packet completes.
//   - i_rst_n low at payload byte 20 -> all outputs 0 in the same cycle; after release no TX until the
//     next pop; pointer is 0.

Source files
------------

// File: rtl/packet_tx_reader_if.sv
// Packet-memory / length-FIFO / TX-PHY bundle for the transmit reader.
// master: the reader itself; slave: the memory, FIFO and PHY side.
interface packet_tx_reader_if #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pFIFO_WIDTH = 11,
    parameter int unsigned pADDR_WIDTH = 12
);
    logic                   i_fifo_empty;
    logic [pFIFO_WIDTH-1:0] i_fifo_len;
    logic                   o_fifo_rd;
    logic [pADDR_WIDTH-1:0] o_ram_raddr;
    logic [pDATA_WIDTH-1:0] i_ram_rdata;
    logic                   o_tx_en;
    logic [pDATA_WIDTH-1:0] o_tx_d;

    modport master (
        input  i_fifo_empty, i_fifo_len, i_ram_rdata,
        output o_fifo_rd, o_ram_raddr, o_tx_en, o_tx_d
    );

    modport slave (
        output i_fifo_empty, i_fifo_len, i_ram_rdata,
        input  o_fifo_rd, o_ram_raddr, o_tx_en, o_tx_d
    );
endinterface

// File: rtl/packet_tx_reader.sv
// Transmit packet reader: pops a length, streams preamble + SFD + payload
// from the packet RAM onto an 8-bit MII-style TX bus, then enforces the IFG.
// Illegal lengths are dropped while keeping the read pointer aligned.
module packet_tx_reader #(
    parameter int unsigned pDATA_WIDTH        = 8,
    parameter int unsigned pMAX_PACKET_LENGHT = 1536,
    parameter int unsigned pDEPTH_RAM         = 2*pMAX_PACKET_LENGHT,
    parameter int unsigned pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
    parameter int unsigned pPREAMBLE_LEN      = 7,
    parameter int unsigned pIFG               = 12
) (
    input  logic                iclk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    packet_tx_reader_if.master  bus,
    output logic                o_busy,
    output logic                o_pkt_done,
    output logic                o_len_err
);
    localparam int unsigned ADDR_W = $clog2(pDEPTH_RAM);
    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned FW     = pFIFO_WIDTH;

    localparam logic [AW1-1:0]         DEPTH_EXT = AW1'(pDEPTH_RAM);
    localparam logic [FW-1:0]          MAX_LEN   = FW'(pMAX_PACKET_LENGHT);
    localparam logic [FW-1:0]          ONE       = FW'(1);
    localparam logic [FW-1:0]          TWO       = FW'(2);
    localparam logic [FW-1:0]          PRE_LAST  = FW'(pPREAMBLE_LEN - 1);
    localparam logic [FW-1:0]          IFG_LAST  = FW'(pIFG - 2);
    localparam logic [pDATA_WIDTH-1:0] PRE_BYTE  = pDATA_WIDTH'(8'h55);
    localparam logic [pDATA_WIDTH-1:0] SFD_BYTE  = pDATA_WIDTH'(8'hD5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_SFD,
        S_DATA,
        S_IFG,
        S_DROP
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          len_q, len_d;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_W-1:0]      raddr_q, raddr_d;
    logic                   tx_en_q, tx_en_d;
    logic [pDATA_WIDTH-1:0] tx_d_q, tx_d_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   fifo_rd;

    // Modular address add: sum one bit wider, then a single conditional subtract.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [FW-1:0]     b);
        logic [AW1-1:0] sum;
        sum = {1'b0, a} + AW1'(b);
        if (sum >= DEPTH_EXT) begin
            sum = sum - DEPTH_EXT;
        end
        return sum[ADDR_W-1:0];
    endfunction

    // Next-state and registered-output computation; every output is one cycle ahead of its flop.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        raddr_d = raddr_q;
        tx_en_d = 1'b0;
        tx_d_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fifo_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_enable && !bus.i_fifo_empty) begin
                    fifo_rd = 1'b1;
                    len_d   = bus.i_fifo_len;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (len_q == '0 || len_q > MAX_LEN) begin
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end else begin
                    tx_en_d = 1'b1;
                    tx_d_d  = PRE_BYTE;
                    cnt_d   = ONE;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
                tx_d_d  = PRE_BYTE;
                if (cnt_q == PRE_LAST) begin
                    // First payload address goes out two cycles before its byte.
                    raddr_d = ptr_q;
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                tx_d_d  = SFD_BYTE;
                cnt_d   = '0;
                if (len_q != ONE) begin
                    raddr_d = wrap_add(raddr_q, ONE);
                end
                state_d = S_DATA;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                tx_d_d  = bus.i_ram_rdata;
                if (cnt_q == len_q - ONE) begin
                    done_d  = 1'b1;
                    ptr_d   = wrap_add(ptr_q, len_q);
                    cnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + TWO < len_q) begin
                        raddr_d = wrap_add(raddr_q, ONE);
                    end
                end
            end
            S_IFG: begin
                // IDLE is reached pIFG-2 cycles early so a pop there lands the next preamble exactly pIFG idle cycles later.
                if (cnt_q == IFG_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DROP: begin
                ptr_d   = wrap_add(ptr_q, len_q);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            raddr_q <= '0;
            tx_en_q <= 1'b0;
            tx_d_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            raddr_q <= raddr_d;
            tx_en_q <= tx_en_d;
            tx_d_q  <= tx_d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The pop strobe is combinational from IDLE, so it is masked while reset is held.
    assign bus.o_fifo_rd   = fifo_rd & i_rst_n;
    assign bus.o_ram_raddr = raddr_q;
    assign bus.o_tx_en     = tx_en_q;
    assign bus.o_tx_d      = tx_d_q;
    assign o_busy          = busy_q;
    assign o_pkt_done      = done_q;
    assign o_len_err       = err_q;

endmodule

// File: tb/tb_packet_tx_reader.sv
// Directed bench for packet_tx_reader: a per-cycle schedule model predicts
// every output from the packet rules; literal checks pin key timeline points.
module tb_packet_tx_reader;
    localparam int DW    = 8;
    localparam int ML    = 1536;
    localparam int DEPTH = 3072;
    localparam int FW    = 11;
    localparam int AW    = 12;
    localparam int FD    = 16;
    localparam int TR    = 8192;
    localparam int SR    = 256;

    typedef struct packed {
        logic          en;
        logic [7:0]    d;
        logic          done;
        logic          err;
        logic          av;
        logic [AW-1:0] a;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic busy, done, err;
    logic [DW-1:0] ram_rdata = '0;

    logic [FW-1:0] fifo_mem [0:FD-1];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int pops   = 0;

    int n_chk  = 0;
    int n_pass = 0;

    int cyc      = 0;
    int free_at  = 0;
    int pop_at   = -100;
    int base     = 0;
    int last_pop = 0;
    int en_cnt   = 0;
    exp_t sched [0:SR-1];
    exp_t e;
    logic exp_pop;
    int   mlen;
    logic [AW-1:0] ma;

    logic          tr_en   [0:TR-1];
    logic [7:0]    tr_d    [0:TR-1];
    logic          tr_done [0:TR-1];
    logic          tr_err  [0:TR-1];
    logic [AW-1:0] tr_addr [0:TR-1];

    packet_tx_reader_if #(.pDATA_WIDTH(DW), .pFIFO_WIDTH(FW), .pADDR_WIDTH(AW)) bus_if ();

    packet_tx_reader #(
        .pDATA_WIDTH(DW),
        .pMAX_PACKET_LENGHT(ML),
        .pDEPTH_RAM(DEPTH),
        .pFIFO_WIDTH(FW),
        .pPREAMBLE_LEN(7),
        .pIFG(12)
    ) dut (
        .iclk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .bus(bus_if.master),
        .o_busy(busy),
        .o_pkt_done(done),
        .o_len_err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    assign bus_if.i_fifo_empty = (wr_cnt == rd_cnt);
    assign bus_if.i_fifo_len   = fifo_mem[rd_cnt % FD];
    assign bus_if.i_ram_rdata  = ram_rdata;

    // Length FIFO (first-word-fall-through) and one-cycle-latency packet RAM.
    always @(posedge clk) begin
        ram_rdata <= ram_byte(bus_if.o_ram_raddr);
        if (bus_if.o_fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            pops   <= pops + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int l);
        fifo_mem[wr_cnt % FD] = FW'(l);
        wr_cnt++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input string name, output int pc);
        int n;
        bit seen;
        n = pops;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pops != n) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL %s: no pop within 200 cycles, required one", name);
        end
        pc = last_pop;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((busy || wr_cnt != rd_cnt) && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 500) begin
            n_chk++;
            $display("FAIL %s: still busy after 500 cycles, required idle", name);
        end
        wait_cycles(3);
    endtask

    // Model + compare: predicts pops and schedules the whole packet timeline, then checks every output.
    always @(negedge clk) begin
        tr_en[cyc % TR]   = bus_if.o_tx_en;
        tr_d[cyc % TR]    = bus_if.o_tx_d;
        tr_done[cyc % TR] = done;
        tr_err[cyc % TR]  = err;
        tr_addr[cyc % TR] = bus_if.o_ram_raddr;
        if (bus_if.o_tx_en) en_cnt++;
        if (bus_if.o_fifo_rd) last_pop = cyc;
        if (!rst_n) begin
            for (int i = 0; i < SR; i++) sched[i] = '0;
            free_at = 0;
            pop_at  = -100;
            base    = 0;
            chk("rst_tx_en", bus_if.o_tx_en, 0);
            chk("rst_tx_d", bus_if.o_tx_d, 0);
            chk("rst_fifo_rd", bus_if.o_fifo_rd, 0);
            chk("rst_raddr", bus_if.o_ram_raddr, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
        end else begin
            e = sched[cyc % SR];
            sched[cyc % SR] = '0;
            exp_pop = (cyc >= free_at) && enable && (wr_cnt != rd_cnt);
            if (exp_pop) begin
                mlen   = int'(fifo_mem[rd_cnt % FD]);
                pop_at = cyc;
                if (mlen == 0 || mlen > ML) begin
                    sched[(cyc + 2) % SR].err = 1'b1;
                    free_at = cyc + 3;
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        sched[(cyc + 2 + i) % SR].en = 1'b1;
                        sched[(cyc + 2 + i) % SR].d  = 8'h55;
                    end
                    sched[(cyc + 9) % SR].en = 1'b1;
                    sched[(cyc + 9) % SR].d  = 8'hD5;
                    for (int k = 0; k < mlen; k++) begin
                        ma = AW'((base + k) % DEPTH);
                        sched[(cyc + 8 + k) % SR].av  = 1'b1;
                        sched[(cyc + 8 + k) % SR].a   = ma;
                        sched[(cyc + 10 + k) % SR].en = 1'b1;
                        sched[(cyc + 10 + k) % SR].d  = ram_byte(ma);
                    end
                    sched[(cyc + 9 + mlen) % SR].done = 1'b1;
                    free_at = cyc + mlen + 20;
                end
                base = (base + mlen) % DEPTH;
            end
            chk("fifo_rd", bus_if.o_fifo_rd, exp_pop);
            chk("tx_en", bus_if.o_tx_en, e.en);
            chk("tx_d", bus_if.o_tx_d, e.d);
            chk("pkt_done", done, e.done);
            chk("len_err", err, e.err);
            chk("busy", busy, (cyc > pop_at && cyc < free_at) ? 1 : 0);
            if (e.av) chk("ram_raddr", bus_if.o_ram_raddr, e.a);
        end
        cyc++;
    end

    // Directed scenarios with literal expectations at key points.
    initial begin
        int p, p1, n0, e0, j;
        #2 rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;

        // Disabled with a queued length: nothing popped.
        push(0);
        n0 = pops;
        wait_cycles(20);
        chk("no_pop_when_disabled", pops - n0, 0);

        // LEN=0 dropped, pointer stays 0.
        e0 = en_cnt;
        enable = 1'b1;
        wait_pop("pop_len0", p);
        wait_idle("idle_len0");
        chk("len0_err_pulse", tr_err[(p + 2) % TR], 1);
        chk("len0_no_tx", en_cnt - e0, 0);

        // LEN=1600 dropped, pointer advances to 1600.
        e0 = en_cnt;
        push(1600);
        wait_pop("pop_len1600", p);
        wait_idle("idle_len1600");
        chk("len1600_err_pulse", tr_err[(p + 2) % TR], 1);
        chk("len1600_no_tx", en_cnt - e0, 0);
        push(2);
        wait_pop("pop_after_1600", p);
        wait_idle("idle_after_1600");
        chk("ptr_after_1600", tr_addr[(p + 8) % TR], 1600);

        // Reset pulse, then the basic 64-byte packet from pointer 0.
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        push(64);
        wait_pop("pop_64", p);
        wait_idle("idle_64");
        chk("t0_preamble", tr_d[(p + 2) % TR], 8'h55);
        chk("t0_tx_en", tr_en[(p + 2) % TR], 1);
        chk("t6_preamble", tr_d[(p + 8) % TR], 8'h55);
        chk("t7_sfd", tr_d[(p + 9) % TR], 8'hD5);
        chk("first_payload", tr_d[(p + 10) % TR], 8'h00);
        chk("last_payload", tr_d[(p + 73) % TR], 8'h3F);
        chk("pkt_done_at_last", tr_done[(p + 73) % TR], 1);
        chk("tx_en_after_last", tr_en[(p + 74) % TR], 0);

        // Three 2026-byte drops move the pointer 64 -> 3070, then a wrapping LEN=4 packet.
        push(2026);
        push(2026);
        push(2026);
        wait_idle("idle_drops");
        push(4);
        wait_pop("pop_wrap", p);
        wait_idle("idle_wrap");
        chk("wrap_addr0", tr_addr[(p + 8) % TR], 3070);
        chk("wrap_addr1", tr_addr[(p + 9) % TR], 3071);
        chk("wrap_addr2", tr_addr[(p + 10) % TR], 0);
        chk("wrap_addr3", tr_addr[(p + 11) % TR], 1);

        // Back-to-back 64 and 100: exactly 12 idle cycles, two pops; pointer starts at 2.
        n0 = pops;
        push(64);
        push(100);
        wait_pop("pop_b2b", p1);
        wait_idle("idle_b2b");
        chk("b2b_pops", pops - n0, 2);
        chk("ptr_after_wrap", tr_addr[(p1 + 8) % TR], 2);
        j = p1 + 74;
        while (!tr_en[j % TR] && j < p1 + 200) j++;
        chk("ifg_idle_cycles", j - (p1 + 73) - 1, 12);

        // i_enable dropped mid-payload: the 30-byte packet completes.
        e0 = en_cnt;
        push(30);
        wait_pop("pop_en_drop", p);
        wait_cycles(15);
        enable = 1'b0;
        wait_idle("idle_en_drop");
        chk("en_drop_tx_cycles", en_cnt - e0, 38);
        chk("en_drop_done", tr_done[(p + 39) % TR], 1);
        enable = 1'b1;

        // Reset at payload byte 20 truncates; pointer returns to 0.
        push(40);
        wait_pop("pop_rst", p);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_en", bus_if.o_tx_en, 0);
        chk("rst_mid_tx_d", bus_if.o_tx_d, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_raddr", bus_if.o_ram_raddr, 0);
        wait_cycles(4);
        rst_n = 1'b1;
        e0 = en_cnt;
        wait_cycles(30);
        chk("no_tx_after_rst", en_cnt - e0, 0);
        push(3);
        wait_pop("pop_after_rst", p);
        wait_idle("idle_after_rst");
        chk("ptr_zero_after_rst", tr_addr[(p + 8) % TR], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
